dm_arbiter: RTL and testbench

Two-requester arbiter for the shared single-port data memory. It sits between the sort controller (requester 0) and the host load/dump port (requester 1), and grants memory ownership to one requester at a time. A lock input keeps the grant through multi-cycle read-compare-write sequences, and a hold counter bounds how long an unlocked owner can starve the other requester.

---
 rtl/dm_arbiter.sv | 131 +++++++++++++
 tb/tb_dm_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the shared single-port data memory, with lock and bounded hold.
// Define DMARB_RR_EN for round-robin tie-breaking from IDLE; default build is fixed priority.
module dm_arbiter #(
    parameter int AW      = 4,
    parameter int DW      = 8,
    parameter int MAXHOLD = 8
) (
    input  logic          a_clk,
    input  logic          a_s_rst,
    input  logic          a_req0,
    input  logic          a_req1,
    input  logic          a_lock0,
    input  logic          a_lock1,
    input  logic          a_we0,
    input  logic          a_we1,
    input  logic [AW-1:0] a_addr0,
    input  logic [AW-1:0] a_addr1,
    input  logic [DW-1:0] a_wd0,
    input  logic [DW-1:0] a_wd1,
    output logic          a_gnt0,
    output logic          a_gnt1,
    output logic          a_rv0,
    output logic          a_rv1,
    output logic [DW-1:0] a_rd,
    output logic          a_busy,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wd,
    output logic          m_we,
    output logic          m_re,
    input  logic [DW-1:0] m_rd
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam int HW = $clog2(MAXHOLD + 1);
    localparam logic [HW-1:0] HMAX = HW'(MAXHOLD);

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          last_q;
    logic          rv0_q, rv1_q;
    logic          tie_pick1;
    logic          acc0, acc1;

`ifdef DMARB_RR_EN
    assign tie_pick1 = ~last_q;
`else
    logic unused_last;
    assign tie_pick1   = 1'b0;
    assign unused_last = last_q;
`endif

    assign a_gnt0 = (state_q == OWN0);
    assign a_gnt1 = (state_q == OWN1);
    assign a_busy = (state_q != IDLE);
    assign acc0   = a_gnt0 & a_req0;
    assign acc1   = a_gnt1 & a_req1;
    assign a_rv0  = rv0_q;
    assign a_rv1  = rv1_q;
    assign a_rd   = m_rd;

    // Forced handover takes precedence over a plain release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (a_req0 && a_req1) state_d = tie_pick1 ? OWN1 : OWN0;
                else if (a_req0)      state_d = OWN0;
                else if (a_req1)      state_d = OWN1;
            end
            OWN0: begin
                if (!a_lock0 && hcnt_q == HMAX)  state_d = OWN1;
                else if (!a_req0 && !a_lock0)    state_d = a_req1 ? OWN1 : IDLE;
            end
            OWN1: begin
                if (!a_lock1 && hcnt_q == HMAX)  state_d = OWN0;
                else if (!a_req1 && !a_lock1)    state_d = a_req0 ? OWN0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hcnt_d = hcnt_q;
        if (state_d != state_q) begin
            hcnt_d = '0;
        end else if (state_q == OWN0 && !a_lock0 && a_req1 && hcnt_q != HMAX) begin
            hcnt_d = hcnt_q + 1'b1;
        end else if (state_q == OWN1 && !a_lock1 && a_req0 && hcnt_q != HMAX) begin
            hcnt_d = hcnt_q + 1'b1;
        end
    end

    always_comb begin
        m_addr = '0;
        m_wd   = '0;
        m_we   = 1'b0;
        m_re   = 1'b0;
        if (acc0) begin
            m_addr = a_addr0;
            m_wd   = a_wd0;
            m_we   = a_we0;
            m_re   = ~a_we0;
        end else if (acc1) begin
            m_addr = a_addr1;
            m_wd   = a_wd1;
            m_we   = a_we1;
            m_re   = ~a_we1;
        end
    end

    always_ff @(posedge a_clk or posedge a_s_rst) begin
        if (a_s_rst) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            last_q  <= 1'b1;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            rv0_q   <= m_re & a_gnt0;
            rv1_q   <= m_re & a_gnt1;
            if (state_d == OWN0 && state_q != OWN0) last_q <= 1'b0;
            if (state_d == OWN1 && state_q != OWN1) last_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: per-cycle expectations from a reference model, random + directed.
module tb_dm_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int MAXHOLD = 4;

    logic          a_clk = 1'b0;
    logic          a_s_rst = 1'b1;
    logic          a_req0 = 0, a_req1 = 0, a_lock0 = 0, a_lock1 = 0, a_we0 = 0, a_we1 = 0;
    logic [AW-1:0] a_addr0 = '0, a_addr1 = '0;
    logic [DW-1:0] a_wd0 = '0, a_wd1 = '0;
    logic          a_gnt0, a_gnt1, a_rv0, a_rv1, a_busy, m_we, m_re;
    logic [DW-1:0] a_rd, m_wd, m_rd;
    logic [AW-1:0] m_addr;

    always #5 a_clk = ~a_clk;

    dm_arbiter #(.AW(AW), .DW(DW), .MAXHOLD(MAXHOLD)) dut (
        .a_clk(a_clk), .a_s_rst(a_s_rst),
        .a_req0(a_req0), .a_req1(a_req1), .a_lock0(a_lock0), .a_lock1(a_lock1),
        .a_we0(a_we0), .a_we1(a_we1), .a_addr0(a_addr0), .a_addr1(a_addr1),
        .a_wd0(a_wd0), .a_wd1(a_wd1), .a_gnt0(a_gnt0), .a_gnt1(a_gnt1),
        .a_rv0(a_rv0), .a_rv1(a_rv1), .a_rd(a_rd), .a_busy(a_busy),
        .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .m_re(m_re), .m_rd(m_rd)
    );

    function automatic logic [7:0] init_val(int i);
        return (i == 3) ? 8'h5A : 8'(i * 37 + 11);
    endfunction

    // Memory model: unwritten locations return their initial pattern.
    logic [7:0] mem_q [16];
    bit         written [16];
    always @(posedge a_clk) begin
        if (m_we) begin
            mem_q[m_addr]   <= m_wd;
            written[m_addr] <= 1'b1;
        end
        if (m_re) m_rd <= written[m_addr] ? mem_q[m_addr] : init_val(int'(m_addr));
    end

    typedef struct {
        bit gnt0, gnt1, rv0, rv1, busy, we, re;
        int addr, wd, rd;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    exp_t e_mon;
    always @(negedge a_clk) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            chk("gnt0", a_gnt0, e_mon.gnt0);
            chk("gnt1", a_gnt1, e_mon.gnt1);
            chk("busy", a_busy, e_mon.busy);
            chk("rv0", a_rv0, e_mon.rv0);
            chk("rv1", a_rv1, e_mon.rv1);
            chk("m_we", m_we, e_mon.we);
            chk("m_re", m_re, e_mon.re);
            chk("m_addr", m_addr, e_mon.addr);
            chk("m_wd", m_wd, e_mon.wd);
            if (e_mon.rv0 || e_mon.rv1) chk("a_rd", a_rd, e_mon.rd);
        end
    end

    // Reference model: owner -1 = nobody, otherwise the requester index.
    int owner = -1;
    int hold = 0;
    int lastm = 1;
    bit prv0 = 0, prv1 = 0;
    int prd = 0;
    int ref_mem[16];

    task automatic cyc(input bit rst, input bit r0, l0, w0, input int ad0, wd0,
                       input bit r1, l1, w1, input int ad1, wd1);
        exp_t e;
        bit   rq[2], lk[2], wr[2];
        int   ad[2], wdv[2];
        int   nxt;
        @(posedge a_clk);
        #1;
        a_s_rst = rst;
        a_req0 = r0; a_lock0 = l0; a_we0 = w0; a_addr0 = AW'(ad0); a_wd0 = DW'(wd0);
        a_req1 = r1; a_lock1 = l1; a_we1 = w1; a_addr1 = AW'(ad1); a_wd1 = DW'(wd1);
        rq[0] = r0; lk[0] = l0; wr[0] = w0; ad[0] = ad0; wdv[0] = wd0;
        rq[1] = r1; lk[1] = l1; wr[1] = w1; ad[1] = ad1; wdv[1] = wd1;
        e = '{default: 0};
        if (rst) begin
            owner = -1; hold = 0; lastm = 1; prv0 = 0; prv1 = 0;
            sb.push_back(e);
            return;
        end
        e.gnt0 = (owner == 0);
        e.gnt1 = (owner == 1);
        e.busy = (owner >= 0);
        e.rv0  = prv0;
        e.rv1  = prv1;
        e.rd   = prd;
        prv0 = 0;
        prv1 = 0;
        if (owner >= 0) begin
            if (rq[owner]) begin
                e.addr = ad[owner];
                e.wd   = wdv[owner];
                if (wr[owner]) begin
                    e.we = 1;
                    ref_mem[ad[owner]] = wdv[owner];
                end else begin
                    e.re = 1;
                    prd  = ref_mem[ad[owner]];
                    if (owner == 0) prv0 = 1; else prv1 = 1;
                end
            end
        end
        if (owner < 0) begin
            if (rq[0] && rq[1]) begin
`ifdef DMARB_RR_EN
                nxt = 1 - lastm;
`else
                nxt = 0;
`endif
            end else if (rq[0]) nxt = 0;
            else if (rq[1])     nxt = 1;
            else                nxt = -1;
        end else if (!lk[owner] && hold == MAXHOLD) begin
            nxt = 1 - owner;
        end else if (!rq[owner] && !lk[owner]) begin
            nxt = rq[1 - owner] ? 1 - owner : -1;
        end else begin
            nxt = owner;
        end
        if (nxt != owner) begin
            hold = 0;
            if (nxt >= 0) lastm = nxt;
        end else if (owner >= 0 && !lk[owner] && rq[1 - owner] && hold < MAXHOLD) begin
            hold++;
        end
        owner = nxt;
        sb.push_back(e);
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = int'(init_val(i));
        // Reset
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Single read by requester 1 from addr 3 (0x5A)
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 0);
        idle_cyc();
        idle_cyc();
        // Tie from IDLE twice, with a return to IDLE in between
        cyc(0, 1, 0, 0, 1, 0, 1, 0, 0, 2, 0);
        cyc(0, 1, 0, 0, 1, 0, 1, 0, 0, 2, 0);
        idle_cyc();
        cyc(0, 1, 0, 0, 1, 0, 1, 0, 0, 2, 0);
        cyc(0, 1, 0, 0, 1, 0, 1, 0, 0, 2, 0);
        idle_cyc();
        idle_cyc();
        // Locked read/read/compare/write by requester 0 while requester 1 waits
        cyc(0, 1, 1, 0, 2, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 2, 0, 1, 0, 0, 9, 0);
        cyc(0, 1, 1, 0, 3, 0, 1, 0, 0, 9, 0);
        cyc(0, 0, 1, 0, 0, 0, 1, 0, 0, 9, 0);
        cyc(0, 1, 1, 1, 2, 8'h77, 1, 0, 0, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 9, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0);
        idle_cyc();
        idle_cyc();
        // Starvation guard: requester 0 streams reads unlocked, requester 1 waits
        cyc(0, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, i, 0, 1, 0, 0, 15 - i, 0);
        cyc(0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 6, 0, 0, 0, 0, 0, 0);
        idle_cyc();
        idle_cyc();
        // Reset in the middle of an OWN0 read
        cyc(0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_cyc();
        // Requester 1 writes 0xC3 to addr 7 then reads it back
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 7, 8'hC3);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 7, 8'hC3);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 0);
        idle_cyc();
        idle_cyc();
        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 299) == 0,
                $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
        end
        idle_cyc();
        idle_cyc();
        @(posedge a_clk);
        @(negedge a_clk);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
